// File: rtl/shiftreg_burst_if.sv
// rtl/shiftreg_burst_if.sv - handshake/data bundle for shiftreg_burst
// SHIFTREG_BURST_ROTATE_EN adds the rot request bit.
interface shiftreg_burst_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             load;
  logic [WIDTH-1:0] d_in;
  logic             start;
  logic             dir;
  logic [CNT_W-1:0] len;
  logic             s_in;
`ifdef SHIFTREG_BURST_ROTATE_EN
  logic             rot;
`endif
  logic [WIDTH-1:0] q;
  logic             s_out;
  logic             busy;
  logic             done;

  modport master (
`ifdef SHIFTREG_BURST_ROTATE_EN
    output rot,
`endif
    output load, d_in, start, dir, len, s_in,
    input  q, s_out, busy, done
  );

  modport slave (
`ifdef SHIFTREG_BURST_ROTATE_EN
    input  rot,
`endif
    input  load, d_in, start, dir, len, s_in,
    output q, s_out, busy, done
  );
endinterface

// File: rtl/shiftreg_burst.sv
// rtl/shiftreg_burst.sv - parallel-load shift register with self-timed shift bursts
// Optional macro SHIFTREG_BURST_ROTATE_EN: latched rot recirculates the exiting bit.
module shiftreg_burst #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic            clk,
  input logic            reset,
  shiftreg_burst_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] q_r;
  logic [CNT_W-1:0] cnt;
  logic             dir_r;
  logic             busy_r;
  logic             done_r;
  logic             fill;

`ifdef SHIFTREG_BURST_ROTATE_EN
  logic rot_r;
  always_comb begin
    fill = bus.s_in;
    if (rot_r) fill = dir_r ? q_r[WIDTH-1] : q_r[0];
  end
`else
  always_comb begin
    fill = bus.s_in;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      q_r    <= '0;
      cnt    <= '0;
      dir_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
`ifdef SHIFTREG_BURST_ROTATE_EN
      rot_r  <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            q_r <= bus.d_in;
          end else if (bus.start) begin
            if (bus.len != '0) begin
              dir_r  <= bus.dir;
              cnt    <= bus.len;
              busy_r <= 1'b1;
              state  <= SHIFT;
`ifdef SHIFTREG_BURST_ROTATE_EN
              rot_r  <= bus.rot;
`endif
            end else begin
              // Zero-length burst completes immediately without touching q or dir_r.
              done_r <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (dir_r) q_r <= {q_r[WIDTH-2:0], fill};
          else       q_r <= {fill, q_r[WIDTH-1:1]};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.q     = q_r;
  assign bus.s_out = dir_r ? q_r[WIDTH-1] : q_r[0];
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
endmodule

// File: tb/tb_shiftreg_burst.sv
// tb/tb_shiftreg_burst.sv - directed and randomized checks of shiftreg_burst
module tb_shiftreg_burst;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  shiftreg_burst_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  shiftreg_burst #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: burst scheduled in absolute edge numbers, shifts as integer arithmetic.
  logic [WIDTH-1:0] m_q = '0;
  logic             m_dir = 1'b0;
  logic             m_rot = 1'b0;
  logic             m_active = 1'b0;
  int               m_end = 0;
  int               m_done_edge = -10;
  int               ecount = 0;

  always @(posedge clk or negedge reset) begin : model
    int  e;
    int  v;
    logic f;
    if (!reset) begin
      m_q <= '0; m_dir <= 1'b0; m_rot <= 1'b0; m_active <= 1'b0; m_done_edge <= -10;
    end else begin
      e = ecount + 1;
      ecount <= e;
      if (m_active) begin
        f = m_rot ? (m_dir ? m_q[WIDTH-1] : m_q[0]) : bus.s_in;
        v = int'(m_q);
        if (m_dir) v = (v * 2 + int'(f)) % (1 << WIDTH);
        else       v = v / 2 + (f ? (1 << (WIDTH-1)) : 0);
        m_q <= WIDTH'(v);
        if (e == m_end) begin
          m_active <= 1'b0;
          m_done_edge <= e;
        end
      end else if (bus.load) begin
        m_q <= bus.d_in;
      end else if (bus.start) begin
        if (bus.len != 0) begin
          m_active <= 1'b1;
          m_end    <= e + int'(bus.len);
          m_dir    <= bus.dir;
`ifdef SHIFTREG_BURST_ROTATE_EN
          m_rot    <= bus.rot;
`endif
        end else begin
          m_done_edge <= e;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("model_q", bus.q, m_q);
      chk("model_busy", bus.busy, m_active);
      chk("model_done", bus.done, (m_done_edge == ecount) && reset);
      chk("model_s_out", bus.s_out, m_dir ? m_q[WIDTH-1] : m_q[0]);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic quiet();
    bus.load = 1'b0; bus.start = 1'b0; bus.dir = 1'b0; bus.len = '0;
    bus.s_in = 1'b0; bus.d_in = '0;
`ifdef SHIFTREG_BURST_ROTATE_EN
    bus.rot = 1'b0;
`endif
  endtask

  task automatic begin_burst(input logic d, input int l, input logic si);
    bus.start = 1'b1; bus.dir = d; bus.len = CNT_W'(l); bus.s_in = si;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    int seq[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    quiet();
    step(2);
    reset = 1'b1;
    checking = 1'b1;

    // Async reset during a burst clears outputs before any clock edge.
    bus.load = 1'b1; bus.d_in = 8'h3C; step(); bus.load = 1'b0;
    begin_burst(1'b1, 5, 1'b1);
    step(2);
    #2 reset = 1'b0;
    #1;
    chk("rst_q", bus.q, 0); chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0); chk("rst_s_out", bus.s_out, 0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_q", bus.q, 0); chk("post_rst_busy", bus.busy, 0); chk("post_rst_done", bus.done, 0);
    end

    // Right burst of 3 from 0xA5 with s_in=1.
    bus.load = 1'b1; bus.d_in = 8'hA5; step(); bus.load = 1'b0;
    chk("t2_load", bus.q, 8'hA5);
    begin_burst(1'b0, 3, 1'b1);
    chk("t2_busy0", bus.busy, 1); chk("t2_sout0", bus.s_out, 1);
    step(); chk("t2_q1", bus.q, 8'hD2); chk("t2_sout1", bus.s_out, 0); chk("t2_busy1", bus.busy, 1);
    step(); chk("t2_q2", bus.q, 8'hE9); chk("t2_sout2", bus.s_out, 1); chk("t2_busy2", bus.busy, 1);
    step(); chk("t2_q3", bus.q, 8'hF4); chk("t2_busy3", bus.busy, 0); chk("t2_done", bus.done, 1);
    step(); chk("t2_done_low", bus.done, 0);

    // Left burst of 2 from 0x81 with s_in=0.
    bus.load = 1'b1; bus.d_in = 8'h81; step(); bus.load = 1'b0;
    begin_burst(1'b1, 2, 1'b0);
    chk("t3_sout", bus.s_out, 1);
    step(); chk("t3_q1", bus.q, 8'h02);
    step(); chk("t3_q2", bus.q, 8'h04); chk("t3_done", bus.done, 1);
    step(); chk("t3_done_low", bus.done, 0);

    // Full-width right burst, then a zero-length start in the done cycle.
    begin_burst(1'b0, 8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bus.s_in = seq[i][0];
      step();
    end
    chk("t4_q", bus.q, 8'h4D); chk("t4_done", bus.done, 1);
    begin_burst(1'b0, 0, 1'b0);
    chk("t4_len0_done", bus.done, 1); chk("t4_len0_busy", bus.busy, 0); chk("t4_len0_q", bus.q, 8'h4D);
    step(); chk("t4_len0_done_low", bus.done, 0);

    // load beats start; load/start during a burst are ignored.
    bus.load = 1'b1; bus.start = 1'b1; bus.d_in = 8'h3C; bus.len = 4'd4;
    step(); bus.load = 1'b0; bus.start = 1'b0;
    chk("t5_load_wins_q", bus.q, 8'h3C); chk("t5_load_wins_busy", bus.busy, 0);
    begin_burst(1'b1, 4, 1'b0);
    bus.load = 1'b1; bus.d_in = 8'hFF; bus.start = 1'b1; bus.len = 4'd9;
    step(); bus.load = 1'b0; bus.start = 1'b0;
    step(2); chk("t5_busy_mid", bus.busy, 1);
    step(); chk("t5_q", bus.q, 8'hC0); chk("t5_busy_end", bus.busy, 0); chk("t5_done", bus.done, 1);

    // Reset after 2 of 5 shifts, then a fresh burst.
    begin_burst(1'b0, 5, 1'b1);
    step(2);
    #2 reset = 1'b0;
    #1; chk("t6_q", bus.q, 0); chk("t6_busy", bus.busy, 0);
    step(); reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(); chk("t6_no_done", bus.done, 0);
    end
    bus.load = 1'b1; bus.d_in = 8'h55; step(); bus.load = 1'b0;
    begin_burst(1'b1, 3, 1'b1);
    step(2); chk("t6_q_mid", bus.q, 8'h57);
    step(); chk("t6_q_end", bus.q, 8'hAF); chk("t6_done", bus.done, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.load  = ($urandom_range(0, 7) == 0);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.dir   = 1'($urandom());
      bus.len   = CNT_W'($urandom());
      bus.s_in  = 1'($urandom());
      bus.d_in  = WIDTH'($urandom());
`ifdef SHIFTREG_BURST_ROTATE_EN
      bus.rot   = 1'($urandom());
`endif
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b0;
        #1;
        step();
        reset = 1'b1;
      end else begin
        step();
      end
    end
    quiet();
    step(20);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/shiftreg_burst.md
Name: shiftreg_burst

Overview:
Parametrised successor to the team's serial-in/serial-out shift register. Holds a WIDTH-bit word that can be parallel-loaded, then shifted right or left by a programmable number of positions in a self-timed burst, with busy/done handshake. Used as a serializer/deserializer front-end: parallel in/out plus serial in/out. Single clock domain.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, 4, width of burst length/counter; burst lengths 0..2^CNT_W-1 (may exceed WIDTH)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low reset
load  input  1  parallel load request (IDLE only)
d_in  input  WIDTH  parallel load data
start  input  1  burst start request (IDLE only)
dir  input  1  burst direction: 0 = right (toward bit 0), 1 = left (toward bit WIDTH-1)
len  input  CNT_W  burst length in shifts
s_in  input  1  serial input, sampled on every shift edge
q  output  WIDTH  register contents
s_out  output  1  serial output: q[0] if dir_r=0, q[WIDTH-1] if dir_r=1
busy  output  1  burst in progress
done  output  1  one-cycle burst completion pulse

Behaviour:
- Reset (reset=0, async): q=0, state=IDLE, busy=0, done=0, cnt=0, dir_r=0, hence s_out=0. Reset mid-burst aborts; no done pulse.
- FSM states: IDLE, SHIFT.
- IDLE, edge with load=1: q<=d_in; start ignored that cycle (load wins).
- IDLE, edge with load=0, start=1, len!=0: dir_r<=dir, cnt<=len, busy<=1, -> SHIFT. No shift on the accepting edge.
- IDLE, edge with load=0, start=1, len=0: no shift, busy stays 0, done=1 for the next cycle.
- SHIFT, every edge: right: q<={s_in, q[WIDTH-1:1]}; left: q<={q[WIDTH-2:0], s_in}; cnt<=cnt-1.
- SHIFT, edge where cnt==1: final shift, -> IDLE, busy<=0, done<=1 for exactly one cycle.
- Latency: start accepted at edge k -> shifts on edges k+1..k+len; busy high after edge k through edge k+len; done high in the cycle after edge k+len, coincident with busy=0.
- load and start while busy: ignored, not queued. dir, len and d_in are only sampled on acceptance.
- done is otherwise 0. A new start may be accepted in the same cycle done is high.
- s_out is combinational from q and dir_r. dir_r changes only on burst acceptance.
- Bits shifted out are discarded.

Optional Feature:
SHIFTREG_BURST_ROTATE_EN: adds input port rot (1 bit), latched with dir on burst acceptance. If latched rot=1, the bit leaving the register replaces s_in (right: q[0] enters q[WIDTH-1]; left: q[WIDTH-1] enters q[0]). If rot=0, s_in is used. Without the macro there is no rot port and the register always shifts in s_in.

Test Plan:
1. reset=0 during traffic -> q=0x00, busy=0, done=0, s_out=0 immediately, without waiting for a clock edge. Release, then idle 3 cycles -> all stay 0.
2. Load d_in=0xA5, then start dir=0 len=3 with s_in=1 held -> q goes 0xD2, 0xE9, 0xF4; s_out before each shift is 1, 0, 1; busy high 3 cycles; done high 1 cycle after the third shift.
3. Load 0x81, start dir=1 len=2 with s_in=0 -> s_out=1 after acceptance; q goes 0x02, then 0x04; done pulses once.
4. WIDTH=8, start dir=0 len=8, s_in sequence 1,0,1,1,0,0,1,0 -> final q=0x4D. Start with len=0 -> done pulse next cycle, busy stays 0, q unchanged.
5. load=1 and start=1 in the same IDLE cycle -> q=d_in and no burst. During a burst, assert load with d_in=0xFF and start -> both ignored; burst completes with the original count.
6. Assert reset mid-burst (after 2 of 5 shifts) -> q=0, busy=0, and done never pulses. After release, a new burst runs normally.
